// File: rtl/lbus_regif.sv
// lbus_regif: LBUS slave holding operand-A buffer and operand-B register, streaming A to a core and capturing its 128-bit result
//   Optional feature: define LBUS_READBACK_EN to make the A/B windows readable (otherwise they read 0).
//   Ports: clk, rst (async, active-high)
//          lbus_a, lbus_di, lbus_wr, lbus_rd -> lbus_do : controller bus (write = addr cycle, data cycle, commit)
//          a, b, blk_krdy, blk_drdy, blk_en             : operands and handshakes to the core
//          blk_rstn, blk_dout, blk_kvld, blk_dvld       : soft reset, result and status from the core
module lbus_regif #(
  parameter int A_DEPTH = 6,
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   lbus_a,
  input  logic [15:0]   lbus_di,
  input  logic          lbus_wr,
  input  logic          lbus_rd,
  output logic [15:0]   lbus_do,
  output logic [DW-1:0] a,
  output logic [DW-1:0] b,
  output logic          blk_krdy,
  output logic          blk_drdy,
  output logic          blk_en,
  input  logic          blk_rstn,
  input  logic [127:0]  blk_dout,
  input  logic          blk_kvld,
  input  logic          blk_dvld
);
  localparam int IW = $clog2(A_DEPTH + 1);
  localparam int AW = $clog2(A_DEPTH);
  localparam logic [15:0] CTRL = 16'h0002;
  localparam logic [15:0] A_BASE = 16'h0100;
  localparam logic [15:0] A_END = 16'(32'h0100 + 2 * A_DEPTH);
  localparam logic [15:0] B_LO = 16'h0110;
  localparam logic [15:0] B_HI = 16'h0111;
  localparam logic [15:0] R_BASE = 16'h0180;
  typedef struct packed {
    logic [A_DEPTH-1:0][DW-1:0] abuf;
    logic [DW-1:0]              breg;
    logic [127:0]               result;
    logic [DW-1:0]              a;
    logic [15:0]                addr_q;
    logic [IW-1:0]              idx;
    logic                       wr_q;
    logic                       busy;
    logic                       done;
    logic                       kvld_seen;
    logic                       krdy;
    logic                       drdy;
  } state_t;
  state_t s, n;
  logic wr_ok, a_wr, b_wr, start;
  logic [AW-1:0] wi;
  logic unused;
  assign unused = lbus_rd;
  // the A window is 256-aligned and shorter than 256 words, so the entry index is just the word address bits above the hi/lo bit
  assign wi = s.addr_q[AW:1];
  assign wr_ok = s.wr_q && !s.busy;
  assign a_wr = wr_ok && s.addr_q >= A_BASE && s.addr_q < A_END;
  assign b_wr = wr_ok && s.addr_q[15:1] == B_LO[15:1];
  // a result arriving on the same edge takes precedence over a start
  assign start = wr_ok && s.addr_q == CTRL && lbus_di[0] && !blk_dvld;
  always_comb begin
    n = s;
    n.wr_q = lbus_wr;
    n.addr_q = lbus_wr ? lbus_a : s.addr_q;
    n.krdy = wr_ok && s.addr_q == B_HI;
    n.kvld_seen = s.kvld_seen | blk_kvld;
    if (a_wr && s.addr_q[0]) n.abuf[wi][DW-1:16] = lbus_di[DW-17:0];
    if (a_wr && !s.addr_q[0]) n.abuf[wi][15:0] = lbus_di;
    if (b_wr && s.addr_q[0]) n.breg[DW-1:16] = lbus_di[DW-17:0];
    if (b_wr && !s.addr_q[0]) n.breg[15:0] = lbus_di;
    // idx points at the next entry to present; once it runs off the end the stream stops and a holds the last entry
    if (s.drdy && s.idx == IW'(A_DEPTH)) n.drdy = 1'b0;
    else if (s.drdy) begin
      n.a = s.abuf[s.idx];
      n.idx = s.idx + IW'(1);
    end
    if (start) begin
      n.busy = 1'b1;
      n.done = 1'b0;
      n.drdy = 1'b1;
      n.a = s.abuf[0];
      n.idx = IW'(1);
    end
    if (blk_dvld) begin
      n.result = blk_dout;
      n.done = 1'b1;
      n.busy = 1'b0;
      n.drdy = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) s <= '0;
    else s <= blk_rstn ? n : '0;
  always_comb begin
    lbus_do = '0;
    if (lbus_a == CTRL) lbus_do = {13'b0, s.kvld_seen, s.done, s.busy};
    if (lbus_a[15:3] == R_BASE[15:3]) lbus_do = s.result[{lbus_a[2:0], 4'b0} +: 16];
`ifdef LBUS_READBACK_EN
    if (lbus_a >= A_BASE && lbus_a < A_END)
      lbus_do = lbus_a[0] ? 16'(s.abuf[lbus_a[AW:1]][DW-1:16]) : s.abuf[lbus_a[AW:1]][15:0];
    if (lbus_a == B_LO) lbus_do = s.breg[15:0];
    if (lbus_a == B_HI) lbus_do = 16'(s.breg[DW-1:16]);
`endif
  end
  assign a = s.a;
  assign b = s.breg;
  assign blk_krdy = s.krdy;
  assign blk_drdy = s.drdy;
  assign blk_en = s.busy;
endmodule

// File: tb/tb_lbus_regif.sv
// tb_lbus_regif: table-driven, directed and randomized checks of lbus_regif against a bus-level register model
module tb_lbus_regif;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] lbus_a = '0;
  logic [15:0] lbus_di = '0;
  logic [15:0] lbus_do;
  logic lbus_wr = 1'b0;
  logic lbus_rd = 1'b1;
  logic [23:0] a, b;
  logic blk_krdy, blk_drdy, blk_en;
  logic blk_rstn = 1'b1;
  logic blk_kvld = 1'b0;
  logic blk_dvld = 1'b0;
  logic [127:0] blk_dout = '0;
  int n_chk = 0;
  int n_fail = 0;
`ifdef LBUS_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  // register model: what a bus master should observe, updated one transaction at a time
  logic [23:0] m_a [6];
  logic [23:0] m_b;
  logic [127:0] m_res;
  bit m_busy, m_done, m_kvld, m_res_ok;
  logic [23:0] exp_a [6];
  typedef struct packed {
    logic        wr;
    logic [15:0] ad;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;
  vec_t v [$];

  lbus_regif dut (
    .clk(clk), .rst(rst), .lbus_a(lbus_a), .lbus_di(lbus_di), .lbus_wr(lbus_wr), .lbus_rd(lbus_rd),
    .lbus_do(lbus_do), .a(a), .b(b), .blk_krdy(blk_krdy), .blk_drdy(blk_drdy), .blk_en(blk_en),
    .blk_rstn(blk_rstn), .blk_dout(blk_dout), .blk_kvld(blk_kvld), .blk_dvld(blk_dvld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_a[i] = '0;
    m_b = '0;
    m_busy = 0;
    m_done = 0;
    m_kvld = 0;
    m_res_ok = 0;
  endtask

  function automatic logic [15:0] exp_rd(input logic [15:0] ad);
    int i;
    if (ad == 16'h0002) return {13'b0, m_kvld, m_done, m_busy};
    if (ad >= 16'h0180 && ad < 16'h0188) return m_res[(ad - 16'h0180) * 16 +: 16];
    if (!RB) return 16'h0000;
    if (ad >= 16'h0100 && ad < 16'h010C) begin
      i = int'(ad - 16'h0100) / 2;
      return ad[0] ? {8'h00, m_a[i][23:16]} : m_a[i][15:0];
    end
    if (ad == 16'h0110) return m_b[15:0];
    if (ad == 16'h0111) return {8'h00, m_b[23:16]};
    return 16'h0000;
  endfunction

  task automatic bus_write(input logic [15:0] ad, input logic [15:0] d);
    bit idle;
    int i;
    idle = !m_busy;
    @(negedge clk);
    lbus_a = ad;
    lbus_wr = 1'b1;
    @(negedge clk);
    lbus_wr = 1'b0;
    lbus_di = d;
    @(negedge clk);
    if (idle) begin
      if (ad >= 16'h0100 && ad < 16'h010C) begin
        i = int'(ad - 16'h0100) / 2;
        if (ad[0]) m_a[i][23:16] = d[7:0];
        else m_a[i][15:0] = d;
      end
      if (ad == 16'h0110) m_b[15:0] = d;
      if (ad == 16'h0111) m_b[23:16] = d[7:0];
      if (ad == 16'h0002 && d[0]) begin
        m_busy = 1;
        m_done = 0;
      end
    end
    chk("krdy_after_write", blk_krdy, idle && ad == 16'h0111);
    chk("b_after_write", b, m_b);
    chk("en_after_write", blk_en, m_busy);
  endtask

  task automatic rd_chk(input string nm, input logic [15:0] ad, input logic [15:0] exp);
    @(negedge clk);
    lbus_a = ad;
    lbus_rd = 1'b0;
    #1;
    chk(nm, lbus_do, exp);
    lbus_rd = 1'b1;
  endtask

  task automatic pulse_dvld(input logic [127:0] d);
    @(negedge clk);
    blk_dvld = 1'b1;
    blk_dout = d;
    @(negedge clk);
    blk_dvld = 1'b0;
    m_res = d;
    m_res_ok = 1;
    m_done = 1;
    m_busy = 0;
    chk("en_after_dvld", blk_en, 1'b0);
    chk("drdy_after_dvld", blk_drdy, 1'b0);
  endtask

  task automatic pulse_kvld();
    @(negedge clk);
    blk_kvld = 1'b1;
    @(negedge clk);
    blk_kvld = 1'b0;
    m_kvld = 1;
  endtask

  function automatic logic [15:0] raddr();
    case ($urandom_range(0, 5))
      0: return 16'h0002;
      1, 2: return 16'h0100 + 16'($urandom_range(0, 11));
      3: return 16'h0110 + 16'($urandom_range(0, 1));
      4: return 16'h0180 + 16'($urandom_range(0, 7));
      default: return 16'($urandom_range(0, 16'h01ff));
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ad;
    model_reset();
    exp_a = '{24'hbbaaaa, 24'hddcccc, 24'hffeeee, 24'h221111, 24'h443333, 24'h665555};
    repeat (10) @(negedge clk);
    chk("reset_a", a, 24'h0);
    chk("reset_b", b, 24'h0);
    chk("reset_blk", {blk_krdy, blk_drdy, blk_en}, 3'b000);
    rst = 1'b0;
    rd_chk("reset_status", 16'h0002, 16'h0000);

    v.push_back({1'b1, 16'h0100, 16'haaaa, 16'h0});
    v.push_back({1'b1, 16'h0101, 16'h00bb, 16'h0});
    v.push_back({1'b1, 16'h0102, 16'hcccc, 16'h0});
    v.push_back({1'b1, 16'h0103, 16'h00dd, 16'h0});
    v.push_back({1'b1, 16'h0104, 16'heeee, 16'h0});
    v.push_back({1'b1, 16'h0105, 16'h00ff, 16'h0});
    v.push_back({1'b1, 16'h0106, 16'h1111, 16'h0});
    v.push_back({1'b1, 16'h0107, 16'h5a22, 16'h0});
    v.push_back({1'b1, 16'h0108, 16'h3333, 16'h0});
    v.push_back({1'b1, 16'h0109, 16'h0044, 16'h0});
    v.push_back({1'b1, 16'h010a, 16'h5555, 16'h0});
    v.push_back({1'b1, 16'h010b, 16'h0066, 16'h0});
    v.push_back({1'b1, 16'h0110, 16'h7777, 16'h0});
    v.push_back({1'b1, 16'h0111, 16'h1288, 16'h0});
    v.push_back({1'b0, 16'h0101, 16'h0, RB ? 16'h00bb : 16'h0});
    v.push_back({1'b0, 16'h0100, 16'h0, RB ? 16'haaaa : 16'h0});
    v.push_back({1'b0, 16'h0107, 16'h0, RB ? 16'h0022 : 16'h0});
    v.push_back({1'b0, 16'h010b, 16'h0, RB ? 16'h0066 : 16'h0});
    v.push_back({1'b0, 16'h0110, 16'h0, RB ? 16'h7777 : 16'h0});
    v.push_back({1'b0, 16'h0111, 16'h0, RB ? 16'h0088 : 16'h0});
    v.push_back({1'b0, 16'h0002, 16'h0, 16'h0000});
    v.push_back({1'b0, 16'h010c, 16'h0, 16'h0000});
    v.push_back({1'b0, 16'h0112, 16'h0, 16'h0000});
    v.push_back({1'b0, 16'h0003, 16'h0, 16'h0000});
    foreach (v[i]) begin
      if (v[i].wr) bus_write(v[i].ad, v[i].d);
      else rd_chk($sformatf("table_rd_%0h", v[i].ad), v[i].ad, v[i].exp);
    end
    chk("b_loaded", b, 24'h887777);
    bus_write(16'h0111, 16'h0088);
    @(negedge clk);
    chk("krdy_one_cycle", blk_krdy, 1'b0);

    bus_write(16'h0002, 16'h0001);
    for (int k = 0; k < 6; k++) begin
      if (k != 0) @(negedge clk);
      chk($sformatf("stream_drdy_%0d", k), blk_drdy, 1'b1);
      chk($sformatf("stream_a_%0d", k), a, exp_a[k]);
      chk($sformatf("stream_en_%0d", k), blk_en, 1'b1);
    end
    @(negedge clk);
    chk("stream_end_drdy", blk_drdy, 1'b0);
    chk("stream_end_a", a, 24'h665555);
    chk("stream_end_en", blk_en, 1'b1);
    bus_write(16'h0100, 16'h1234);
    bus_write(16'h0002, 16'h0001);
    chk("busy_start_drdy", blk_drdy, 1'b0);
    chk("busy_start_a", a, 24'h665555);
    rd_chk("status_busy", 16'h0002, 16'h0001);
    pulse_dvld(128'h0123456789abcdef0123456789abcdef);
    rd_chk("status_done", 16'h0002, 16'h0002);
    rd_chk("result_w0", 16'h0180, 16'hcdef);
    rd_chk("result_w7", 16'h0187, 16'h0123);
    rd_chk("a0_unchanged", 16'h0100, RB ? 16'haaaa : 16'h0);

    pulse_kvld();
    rd_chk("status_kvld", 16'h0002, 16'h0006);
    bus_write(16'h0002, 16'h0001);
    rd_chk("status_restart", 16'h0002, 16'h0005);
    pulse_dvld(128'h1);

    @(negedge clk);
    lbus_a = 16'h0002;
    lbus_wr = 1'b1;
    @(negedge clk);
    lbus_wr = 1'b0;
    lbus_di = 16'h0001;
    blk_dvld = 1'b1;
    blk_dout = 128'hfeedface_00000000_00000000_0000beef;
    @(negedge clk);
    blk_dvld = 1'b0;
    m_res = blk_dout;
    m_done = 1;
    chk("dvld_wins_en", blk_en, 1'b0);
    chk("dvld_wins_drdy", blk_drdy, 1'b0);
    rd_chk("dvld_wins_status", 16'h0002, 16'h0006);
    rd_chk("dvld_wins_res", 16'h0187, 16'hfeed);

    bus_write(16'h0002, 16'h0001);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_a", a, 24'h0);
    chk("abort_b", b, 24'h0);
    chk("abort_blk", {blk_krdy, blk_drdy, blk_en}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    rd_chk("abort_status", 16'h0002, 16'h0000);

    bus_write(16'h0110, 16'h4321);
    pulse_kvld();
    @(negedge clk);
    blk_rstn = 1'b0;
    @(negedge clk);
    blk_rstn = 1'b1;
    model_reset();
    chk("softrst_b", b, 24'h0);
    rd_chk("softrst_status", 16'h0002, 16'h0000);

    for (int t = 0; t < 400; t++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          ad = raddr();
          bus_write(ad, 16'($urandom));
        end
        4, 5, 6: begin
          ad = raddr();
          if (!(ad >= 16'h0180 && ad < 16'h0188 && !m_res_ok)) rd_chk("rand_rd", ad, exp_rd(ad));
        end
        7: pulse_dvld({$urandom, $urandom, $urandom, $urandom});
        8: pulse_kvld();
        default: repeat ($urandom_range(1, 4)) @(negedge clk);
      endcase
    end
    @(negedge clk);
    chk("final_b", b, m_b);
    chk("final_en", blk_en, m_busy);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
